// File: rtl/sirv_ncyc_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sirv_ncyc_sram_ctrl
// Desc   : N-cycle read-latency SRAM controller with in-order response FIFO
//          and gated RAM clock.
// Rev    : 1.0  initial release
// ============================================================================
module sirv_ncyc_sram_ctrl #(
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int AW     = 32,
  parameter int AW_LSB = 2,
  parameter int USR_W  = 3,
  parameter int RD_LAT = 2,
  parameter int RSP_DP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tcm_cgstop,
  input  logic                 test_mode,
  input  logic                 uop_cmd_valid,
  output logic                 uop_cmd_ready,
  input  logic                 uop_cmd_read,
  input  logic [AW-1:0]        uop_cmd_addr,
  input  logic [DW-1:0]        uop_cmd_wdata,
  input  logic [MW-1:0]        uop_cmd_wmask,
  input  logic [USR_W-1:0]     uop_cmd_usr,
  output logic                 uop_rsp_valid,
  input  logic                 uop_rsp_ready,
  output logic [DW-1:0]        uop_rsp_rdata,
  output logic [USR_W-1:0]     uop_rsp_usr,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic [AW-AW_LSB-1:0] ram_addr,
  output logic [MW-1:0]        ram_wem,
  output logic [DW-1:0]        ram_din,
  input  logic [DW-1:0]        ram_dout,
  output logic                 clk_ram,
  output logic                 sram_ctrl_active
);

  localparam int c_CNT_W = $clog2(RSP_DP + 1);
  localparam int c_PTR_W = (RSP_DP > 1) ? $clog2(RSP_DP) : 1;

  logic               w_cmd_hsk;
  logic               w_rsp_hsk;
  logic [c_CNT_W-1:0] r_cnt;

  // --------------------------------------------------------------------------
  // Outstanding-command credit: covers pipeline plus FIFO, so the FIFO can
  // never be pushed while full without a matching pop.
  // --------------------------------------------------------------------------
  assign uop_cmd_ready = (r_cnt < c_CNT_W'(RSP_DP));
  assign w_cmd_hsk     = uop_cmd_valid & uop_cmd_ready;
  assign w_rsp_hsk     = uop_rsp_valid & uop_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cmd_hsk & ~w_rsp_hsk) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end else if (~w_cmd_hsk & w_rsp_hsk) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  assign sram_ctrl_active = uop_cmd_valid | (r_cnt != '0);

  // --------------------------------------------------------------------------
  // RAM command side: pure pass-through
  // --------------------------------------------------------------------------
  logic w_unused_addr_lsb;

  assign ram_cs            = w_cmd_hsk;
  assign ram_we            = ~uop_cmd_read;
  assign ram_addr          = uop_cmd_addr[AW-1:AW_LSB];
  assign ram_wem           = uop_cmd_wmask;
  assign ram_din           = uop_cmd_wdata;
  assign w_unused_addr_lsb = ^uop_cmd_addr[AW_LSB-1:0];

  // --------------------------------------------------------------------------
  // Latency pipeline: never stalls, stage RD_LAT-1 lines up with ram_dout
  // --------------------------------------------------------------------------
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_rd;
  logic [USR_W-1:0]  r_pipe_usr [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_rd  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_usr[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_cmd_hsk;
      r_pipe_rd[0]  <= uop_cmd_read;
      r_pipe_usr[0] <= uop_cmd_usr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_rd[i]  <= r_pipe_rd[i-1];
        r_pipe_usr[i] <= r_pipe_usr[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  logic               w_push;
  logic               w_pop;
  logic [DW-1:0]      w_push_rdata;
  logic [DW-1:0]      r_fifo_rdata [RSP_DP];
  logic [USR_W-1:0]   r_fifo_usr   [RSP_DP];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_fifo_cnt;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    if (p == c_PTR_W'(RSP_DP - 1)) begin
      return '0;
    end
    return p + c_PTR_W'(1);
  endfunction

  assign w_push       = r_pipe_vld[RD_LAT-1];
  assign w_pop        = w_rsp_hsk;
  assign w_push_rdata = r_pipe_rd[RD_LAT-1] ? ram_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      if (w_push & ~w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
      end else if (~w_push & w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
      end
    end
  end

  // Full-with-pop writes the slot being popped; the head is read before the edge.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rdata[r_wptr] <= w_push_rdata;
      r_fifo_usr[r_wptr]   <= r_pipe_usr[RD_LAT-1];
    end
  end

  assign uop_rsp_valid = (r_fifo_cnt != '0);
  assign uop_rsp_rdata = r_fifo_rdata[r_rptr];
  assign uop_rsp_usr   = r_fifo_usr[r_rptr];

  // --------------------------------------------------------------------------
  // RAM clock gate: enable captured while clk is low so clk_ram is glitch-free
  // --------------------------------------------------------------------------
  logic w_ram_clk_en;
  logic r_cg_en;

  assign w_ram_clk_en = ram_cs | tcm_cgstop | (|r_pipe_vld);

  always_latch begin
    if (!clk) begin
      r_cg_en = w_ram_clk_en | test_mode;
    end
  end

  assign clk_ram = clk & r_cg_en;

endmodule
`default_nettype wire

// File: tb/tb_sirv_ncyc_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sirv_ncyc_sram_ctrl
// Desc   : Self-checking bench; responses predicted from an in-order queue of
//          accepted commands stamped with their acceptance cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sirv_ncyc_sram_ctrl;

  localparam int DW     = 32;
  localparam int MW     = 4;
  localparam int AW     = 32;
  localparam int AW_LSB = 2;
  localparam int USR_W  = 3;
  localparam int RD_LAT = 2;
  localparam int RSP_DP = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tcm_cgstop;
  logic                 test_mode;
  logic                 uop_cmd_valid;
  logic                 uop_cmd_ready;
  logic                 uop_cmd_read;
  logic [AW-1:0]        uop_cmd_addr;
  logic [DW-1:0]        uop_cmd_wdata;
  logic [MW-1:0]        uop_cmd_wmask;
  logic [USR_W-1:0]     uop_cmd_usr;
  logic                 uop_rsp_valid;
  logic                 uop_rsp_ready;
  logic [DW-1:0]        uop_rsp_rdata;
  logic [USR_W-1:0]     uop_rsp_usr;
  logic                 ram_cs;
  logic                 ram_we;
  logic [AW-AW_LSB-1:0] ram_addr;
  logic [MW-1:0]        ram_wem;
  logic [DW-1:0]        ram_din;
  logic [DW-1:0]        ram_dout;
  logic                 clk_ram;
  logic                 sram_ctrl_active;

  sirv_ncyc_sram_ctrl #(
    .DW(DW), .MW(MW), .AW(AW), .AW_LSB(AW_LSB),
    .USR_W(USR_W), .RD_LAT(RD_LAT), .RSP_DP(RSP_DP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tcm_cgstop       (tcm_cgstop),
    .test_mode        (test_mode),
    .uop_cmd_valid    (uop_cmd_valid),
    .uop_cmd_ready    (uop_cmd_ready),
    .uop_cmd_read     (uop_cmd_read),
    .uop_cmd_addr     (uop_cmd_addr),
    .uop_cmd_wdata    (uop_cmd_wdata),
    .uop_cmd_wmask    (uop_cmd_wmask),
    .uop_cmd_usr      (uop_cmd_usr),
    .uop_rsp_valid    (uop_rsp_valid),
    .uop_rsp_ready    (uop_rsp_ready),
    .uop_rsp_rdata    (uop_rsp_rdata),
    .uop_rsp_usr      (uop_rsp_usr),
    .ram_cs           (ram_cs),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_wem          (ram_wem),
    .ram_din          (ram_din),
    .ram_dout         (ram_dout),
    .clk_ram          (clk_ram),
    .sram_ctrl_active (sram_ctrl_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ram_edges = 0;

  always @(posedge clk_ram) ram_edges++;

  typedef struct {
    int         t;
    logic       rd;
    logic [2:0] usr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] dout_hist [0:4095];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at the following negedge.
  task automatic step(input logic v, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] wm, input logic [2:0] us,
                      input logic rr, input logic [31:0] dout, output logic acc);
    logic        exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_rdata;
    ent_t        e;
    uop_cmd_valid = v;
    uop_cmd_read  = rd;
    uop_cmd_addr  = addr;
    uop_cmd_wdata = wd;
    uop_cmd_wmask = wm;
    uop_cmd_usr   = us;
    uop_rsp_ready = rr;
    ram_dout      = dout;
    dout_hist[cyc] = dout;
    #4;
    exp_rdy = (q.size() < RSP_DP);
    exp_vld = (q.size() > 0) && (q[0].t + RD_LAT + 1 <= cyc);
    chk("cmd_ready", {63'd0, uop_cmd_ready}, {63'd0, exp_rdy});
    chk("rsp_valid", {63'd0, uop_rsp_valid}, {63'd0, exp_vld});
    if (exp_vld) begin
      exp_rdata = q[0].rd ? dout_hist[q[0].t + RD_LAT] : 32'h0;
      chk("rsp_rdata", 64'(uop_rsp_rdata), 64'(exp_rdata));
      chk("rsp_usr", 64'(uop_rsp_usr), 64'(q[0].usr));
    end
    chk("ram_cs", {63'd0, ram_cs}, {63'd0, v & exp_rdy});
    chk("ram_we", {63'd0, ram_we}, {63'd0, ~rd});
    chk("ram_addr", 64'(ram_addr), 64'(addr >> AW_LSB));
    chk("ram_wem", 64'(ram_wem), 64'(wm));
    chk("ram_din", 64'(ram_din), 64'(wd));
    chk("active", {63'd0, sram_ctrl_active}, {63'd0, v | (q.size() != 0)});
    if (rr && exp_vld) void'(q.pop_front());
    acc = v && exp_rdy;
    if (acc) begin
      e.t = cyc; e.rd = rd; e.usr = us;
      q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0, rr, $urandom, a);
  endtask

  initial begin
    logic acc;
    int   e0;
    rst = 1'b1; tcm_cgstop = 1'b0; test_mode = 1'b0;
    uop_cmd_valid = 1'b0; uop_cmd_read = 1'b1; uop_cmd_addr = '0;
    uop_cmd_wdata = '0; uop_cmd_wmask = '0; uop_cmd_usr = '0;
    uop_rsp_ready = 1'b0; ram_dout = '0;
    @(posedge clk); #1;
    chk("rst_rsp_valid", {63'd0, uop_rsp_valid}, 64'd0);
    chk("rst_cmd_ready", {63'd0, uop_cmd_ready}, 64'd1);
    chk("rst_active_idle", {63'd0, sram_ctrl_active}, 64'd0);
    uop_cmd_valid = 1'b1; #1;
    chk("rst_active_valid", {63'd0, sram_ctrl_active}, 64'd1);
    uop_cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Read example: addr 0x10, usr 5, data on ram_dout two cycles later
    step(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 3'd5, 1'b0, 32'h0, acc);
    chk("ex_rd_addr", 64'(ram_addr), 64'h4);
    step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, acc);
    step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0, 1'b0, 32'hA5A5_A5A5, acc);
    step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0, 1'b1, 32'h0, acc);
    idle(2, 1'b1);

    // Write example: zero response data after RD_LAT+1
    step(1'b0, 1'b0, 32'h8, 32'h1234, 4'h3, 3'd2, 1'b1, 32'hDEAD_BEEF, acc);
    chk("ex_wr_we", {63'd0, ram_we}, 64'd1);
    step(1'b1, 1'b0, 32'h8, 32'h1234, 4'h3, 3'd2, 1'b1, 32'hDEAD_BEEF, acc);
    idle(4, 1'b1);

    // Backpressure: three back-to-back reads with no response ready
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'h0, 4'h0, 3'(i + 1), 1'b0, $urandom, acc);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 32'h108, 32'h0, 4'h0, 3'd3, 1'b0, $urandom, acc);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++)
      step(1'b1, 1'b1, 32'h108, 32'h0, 4'h0, 3'd3, 1'b1, $urandom, acc);
    idle(6, 1'b1);

    // Streaming reads with responses always accepted: push/pop overlap
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'(i % 3 != 0), $urandom, $urandom, 4'($urandom), 3'(i), 1'b1, $urandom, acc);
    idle(5, 1'b1);

    // Reset with responses outstanding
    step(1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 3'd6, 1'b0, $urandom, acc);
    step(1'b1, 1'b1, 32'h24, 32'h0, 4'h0, 3'd7, 1'b0, $urandom, acc);
    step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0, 1'b0, $urandom, acc);
    step(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0, 1'b0, $urandom, acc);
    rst = 1'b1; #1;
    chk("rst_mid_rsp_valid", {63'd0, uop_rsp_valid}, 64'd0);
    chk("rst_mid_cmd_ready", {63'd0, uop_cmd_ready}, 64'd1);
    chk("rst_mid_active", {63'd0, sram_ctrl_active}, 64'd1);
    uop_cmd_valid = 1'b0;
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc += 2;
    rst = 1'b0;
    idle(8, 1'b1);

    // RAM clock gating
    e0 = ram_edges;
    idle(5, 1'b0);
    chk("cg_idle", 64'(ram_edges - e0), 64'd0);
    tcm_cgstop = 1'b1;
    e0 = ram_edges;
    idle(5, 1'b0);
    chk("cg_cgstop", 64'(ram_edges - e0), 64'd5);
    tcm_cgstop = 1'b0;
    idle(1, 1'b0);
    test_mode = 1'b1;
    e0 = ram_edges;
    idle(5, 1'b0);
    chk("cg_test_mode", 64'(ram_edges - e0), 64'd5);
    test_mode = 1'b0;
    idle(2, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), $urandom, $urandom,
           4'($urandom), 3'($urandom), 1'($urandom_range(0, 9) < 6), $urandom, acc);
    idle(8, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
